// File: rtl/uart_frame_arb.sv
// uart_frame_arb: round-robin framer sharing one 8N1 UART transmitter between two channels.
// Define UART_FRAME_CKSUM_EN to append a sum-mod-256 checksum byte (ID, LEN, payload) to each frame.
module uart_frame_arb #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int LEN_W = 4
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             ch0_req,
  input  logic [LEN_W-1:0] ch0_len,
  input  logic [7:0]       ch0_data,
  output logic             ch0_rd,
  output logic             ch0_done,
  input  logic             ch1_req,
  input  logic [LEN_W-1:0] ch1_len,
  input  logic [7:0]       ch1_data,
  output logic             ch1_rd,
  output logic             ch1_done,
  output logic             tx_vld,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, HDR, ID, LEN, PAY, CKS, WAIT, DONE} state_t;
  state_t state, state_n, after, after_n, fin;
  logic gnt, last_gnt, pick, issue, grant;
  logic [LEN_W-1:0] len, cnt, cnt_inc;
  logic [7:0] cur, byte_q, cks_byte;
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] cks;
  assign cks_byte = cks;
  assign fin = CKS;
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) cks <= '0;
    else if (grant) cks <= '0;
    else if (state inside {ID, LEN, PAY}) cks <= cks + cur;
`else
  assign cks_byte = 8'h00;
  assign fin = DONE;
`endif
  assign grant = state == IDLE && (ch0_req || ch1_req);
  assign pick = (ch0_req && ch1_req) ? ~last_gnt : ch1_req;
  assign issue = state inside {HDR, ID, LEN, PAY, CKS};
  assign cnt_inc = cnt + 1'b1;
  assign cur = state == HDR ? HEADER :
               state == ID  ? {7'b0, gnt} :
               state == LEN ? 8'(len) :
               state == PAY ? (gnt ? ch1_data : ch0_data) : cks_byte;
  assign tx_vld = issue;
  assign tx_data = issue ? cur : byte_q;
  assign ch0_rd = state == PAY && !gnt;
  assign ch1_rd = state == PAY && gnt;
  assign ch0_done = state == DONE && !gnt;
  assign ch1_done = state == DONE && gnt;
  assign busy = state != IDLE;
  // after remembers which issue state follows the current byte's WAIT
  always_comb begin
    state_n = state;
    after_n = after;
    case (state)
      IDLE: state_n = grant ? HDR : IDLE;
      HDR:  after_n = ID;
      ID:   after_n = LEN;
      LEN:  after_n = len == '0 ? fin : PAY;
      PAY:  after_n = cnt_inc == len ? fin : PAY;
      CKS:  after_n = DONE;
      WAIT: state_n = tx_done ? after : WAIT;
      DONE: state_n = IDLE;
    endcase
    if (issue) state_n = WAIT;
  end
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      after <= IDLE;
      gnt <= 1'b0;
      last_gnt <= 1'b1;
      len <= '0;
      cnt <= '0;
      byte_q <= '0;
    end else begin
      state <= state_n;
      after <= after_n;
      if (grant) begin
        gnt <= pick;
        len <= pick ? ch1_len : ch0_len;
        cnt <= '0;
      end
      if (issue) byte_q <= cur;
      if (state == PAY) cnt <= cnt_inc;
      if (state == DONE) last_gnt <= gnt;
    end
endmodule

// File: tb/tb_uart_frame_arb.sv
// tb_uart_frame_arb: directed frame vectors against a transmitter model with fixed tx_done latency.
module tb_uart_frame_arb;
  localparam int LEN_W = 4;
  localparam int LAT = 100;
`ifdef UART_FRAME_CKSUM_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 3;
`endif
  logic clk_50 = 1'b0, rst_n = 1'b0, ch0_req = 1'b0, ch1_req = 1'b0, tx_done = 1'b0;
  logic [LEN_W-1:0] ch0_len = '0, ch1_len = '0;
  logic [7:0] ch0_data, ch1_data, tx_data;
  logic ch0_rd, ch0_done, ch1_rd, ch1_done, tx_vld, busy;
  logic [7:0] pay0 [32];
  logic [7:0] pay1 [32];
  int idx0 = 0, idx1 = 0, total = 0, bad = 0, cyc = 0, cd = 0, last_vld = 0, rd0 = 0, rd1 = 0;
  bit early = 1'b0, kick = 1'b0;
  logic [7:0] got [$];
  int dones [$];
  typedef struct {bit ch; int len; logic [7:0] base; logic [7:0] cks;} vec_t;
  vec_t vecs [5];

  always #10 clk_50 = ~clk_50;
  assign ch0_data = pay0[idx0[4:0]];
  assign ch1_data = pay1[idx1[4:0]];

  uart_frame_arb dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_data(ch0_data), .ch0_rd(ch0_rd), .ch0_done(ch0_done),
    .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_data(ch1_data), .ch1_rd(ch1_rd), .ch1_done(ch1_done),
    .tx_vld(tx_vld), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int at(input int i);
    return i < got.size() ? int'(got[i]) : -1;
  endfunction

  // transmitter model and bus monitor, sampling on the falling edge
  initial forever begin
    @(negedge clk_50);
    cyc++;
    tx_done = 1'b0;
    if (!rst_n) begin
      cd = 0;
      last_vld = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
      if (kick) begin
        tx_done = 1'b1;
        kick = 1'b0;
      end
      if (tx_vld) begin
        chk("vld_in_flight", cd, 0);
        if (last_vld > 0) begin
          total++;
          if (cyc - last_vld < LAT + 1) begin
            bad++;
            $display("FAIL vld_gap: got %0d cycles want >= %0d", cyc - last_vld, LAT + 1);
          end
        end
        got.push_back(tx_data);
        last_vld = cyc;
        cd = LAT;
        if (early) tx_done = 1'b1;
      end
      if (ch0_rd || ch1_rd) chk("rd_with_vld", int'(tx_vld), 1);
      if (ch0_rd) begin rd0++; idx0++; end
      if (ch1_rd) begin rd1++; idx1++; end
      if (ch0_done) dones.push_back(0);
      if (ch1_done) dones.push_back(1);
    end
  end

  task automatic load(input bit ch, input logic [7:0] base);
    for (int i = 0; i < 32; i++) begin
      if (ch) pay1[i] = 8'(base * (i + 1));
      else pay0[i] = 8'(base * (i + 1));
    end
    if (ch) idx1 = 0;
    else idx0 = 0;
  endtask

  task automatic clear_log();
    got.delete();
    dones.delete();
    rd0 = 0;
    rd1 = 0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (dones.size() < n && t < 60 * (LAT + 2)) begin
      @(negedge clk_50); #1;
      t++;
    end
    chk("done_count", dones.size(), n);
  endtask

  task automatic run_frame(input bit ch, input int len, input logic [7:0] base, input logic [7:0] cks);
    logic [7:0] exp [$];
    clear_log();
    load(ch, base);
    if (ch) begin ch1_len = LEN_W'(len); ch1_req = 1'b1; end
    else begin ch0_len = LEN_W'(len); ch0_req = 1'b1; end
    for (int i = 0; i < 4 && !busy; i++) begin @(negedge clk_50); #1; end
    chk("busy_at_grant", int'(busy), 1);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    ch0_len = '0;
    ch1_len = '0;
    wait_done(1);
    exp.push_back(8'hA5);
    exp.push_back({7'b0, ch});
    exp.push_back(8'(len));
    for (int i = 0; i < len; i++) exp.push_back(8'(base * (i + 1)));
`ifdef UART_FRAME_CKSUM_EN
    exp.push_back(cks);
`endif
    chk("frame_bytes", got.size(), len + EXTRA);
    for (int i = 0; i < exp.size(); i++) chk($sformatf("byte%0d", i), at(i), int'(exp[i]));
    chk("rd_own", ch ? rd1 : rd0, len);
    chk("rd_other", ch ? rd0 : rd1, 0);
    if (dones.size() > 0) chk("done_ch", dones[0], int'(ch));
    @(negedge clk_50); #1;
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 2, 8'h11, 8'h35};
    vecs[1] = '{1'b1, 0, 8'h00, 8'h01};
    vecs[2] = '{1'b1, 3, 8'h01, 8'h0A};
    vecs[3] = '{1'b0, 15, 8'h10, 8'h8F};
    vecs[4] = '{1'b1, 1, 8'h80, 8'h82};
    load(0, 8'h00);
    load(1, 8'h00);
    repeat (3) @(negedge clk_50);
    #1;
    chk("rst_tx_vld", int'(tx_vld), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'({ch0_rd, ch1_rd, ch0_done, ch1_done}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);
    #1;
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[v]) run_frame(vecs[v].ch, vecs[v].len, vecs[v].base, vecs[v].cks);

    // both requests held: strict alternation, starting with ch0 since ch1 went last
    clear_log();
    load(0, 8'h40);
    load(1, 8'h50);
    ch0_len = 4'd1;
    ch1_len = 4'd1;
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    wait_done(4);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < dones.size()) chk("alt_done", dones[k], k % 2);
      chk("alt_hdr", at(k * (1 + EXTRA)), 8'hA5);
      chk("alt_id", at(k * (1 + EXTRA) + 1), k % 2);
    end
    chk("alt_bytes", got.size(), 4 * (1 + EXTRA));
    chk("alt_rd0", rd0, 2);
    chk("alt_rd1", rd1, 2);
    repeat (3) @(negedge clk_50);
    #1;
    chk("alt_stop", int'(busy), 0);

    // tx_done coincident with every issue state is ignored, and again while idle
    early = 1'b1;
    run_frame(0, 1, 8'h33, 8'h34);
    early = 1'b0;
    n = got.size();
    for (int k = 0; k < 3; k++) begin
      kick = 1'b1;
      repeat (3) @(negedge clk_50);
      #1;
    end
    chk("idle_kick_vld", got.size(), n);
    chk("idle_kick_busy", int'(busy), 0);

    // reset during payload: immediate quiet outputs, no done pulse
    clear_log();
    load(0, 8'h07);
    ch0_len = 4'd5;
    ch0_req = 1'b1;
    for (int t = 0; t < 10 * (LAT + 2) && !ch0_rd; t++) begin @(negedge clk_50); #1; end
    chk("pay_reached", int'(ch0_rd), 1);
    rst_n = 1'b0;
    ch0_req = 1'b0;
    #1;
    chk("arst_vld", int'(tx_vld), 0);
    chk("arst_data", int'(tx_data), 0);
    chk("arst_rd", int'(ch0_rd), 0);
    chk("arst_busy", int'(busy), 0);
    repeat (3) @(negedge clk_50);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);
    #1;
    chk("arst_no_done", dones.size(), 0);

    // first tie after reset goes to ch0 and starts with the header
    clear_log();
    load(0, 8'h09);
    load(1, 8'h09);
    ch0_len = '0;
    ch1_len = '0;
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    wait_done(1);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    if (dones.size() > 0) chk("tie_ch", dones[0], 0);
    chk("tie_hdr", at(0), 8'hA5);
    chk("tie_id", at(1), 0);
    chk("tie_bytes", got.size(), EXTRA);
    repeat (3) @(negedge clk_50);
    #1;
    chk("tie_stop", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
